// File: rtl/spi_burst_slave.sv
// spi_burst_slave: SPI slave endpoint with a parametrised single-port register memory.
// One opcode per frame (SS_n low interval): set write/read pointer, or burst-write /
// burst-read words with auto-incrementing, wrapping pointers. MOSI sampled and MISO
// updated on posedge clk, MSB first.
module spi_burst_slave #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MEM_DEPTH  = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic SS_n,
   input  logic MOSI,
   output logic MISO
);

   // One shift register serves address, write data and read data
   localparam int unsigned MaxW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int unsigned CntW = $clog2(MaxW);
   localparam int unsigned IdxW = $clog2(MEM_DEPTH);

   localparam logic [CntW-1:0]       AddrLast = CntW'(ADDR_WIDTH - 1);
   localparam logic [CntW-1:0]       DataLast = CntW'(DATA_WIDTH - 1);
   localparam logic [ADDR_WIDTH-1:0] PtrMask  = ADDR_WIDTH'(MEM_DEPTH - 1);

   typedef enum logic [2:0] {
      StIdle,
      StGetOp,
      StAddr,
      StWdata,
      StRdata,
      StDone
   } state_e;

   state_e                r_state;
   state_e                w_state_d;
   logic [CntW-1:0]       r_cnt;
   logic [CntW-1:0]       w_cnt_d;
   logic [MaxW-1:0]       r_shift;
   logic [MaxW-1:0]       w_shift_d;
   logic                  r_op_hi;
   logic                  w_op_hi_d;
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] w_wr_ptr_d;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH-1:0] w_rd_ptr_d;
   logic                  r_miso;
   logic                  w_miso_d;

   logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
   logic                  w_mem_we;
   logic [DATA_WIDTH-1:0] w_mem_wdata;
   logic [DATA_WIDTH-1:0] w_rd_word;
   logic [MaxW-1:0]       w_shift_in;
   logic [ADDR_WIDTH-1:0] w_wr_inc;
   logic [ADDR_WIDTH-1:0] w_rd_inc;

   assign w_shift_in = {r_shift[MaxW-2:0], MOSI};
   assign w_rd_word  = r_mem[r_rd_ptr[IdxW-1:0]];
   assign w_wr_inc   = (r_wr_ptr + ADDR_WIDTH'(1)) & PtrMask;
   assign w_rd_inc   = (r_rd_ptr + ADDR_WIDTH'(1)) & PtrMask;
   assign MISO       = r_miso;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   // FSM next-state: SS_n high always aborts the frame
   always_comb begin
      w_state_d = r_state;
      if (SS_n) begin
         w_state_d = StIdle;
      end else begin
         case (r_state)
            StIdle:  w_state_d = StGetOp;
            StGetOp: begin
               if (r_cnt != '0) begin
                  case ({r_op_hi, MOSI})
                     2'b01:   w_state_d = StWdata;
                     2'b11:   w_state_d = StRdata;
                     default: w_state_d = StAddr;
                  endcase
               end
            end
            StAddr:  if (r_cnt == AddrLast) w_state_d = StDone;
            default: ;
         endcase
      end
   end

   // FSM outputs: datapath next values, memory write strobe and next MISO bit
   always_comb begin
      w_cnt_d     = r_cnt;
      w_shift_d   = r_shift;
      w_op_hi_d   = r_op_hi;
      w_wr_ptr_d  = r_wr_ptr;
      w_rd_ptr_d  = r_rd_ptr;
      w_miso_d    = 1'b0;
      w_mem_we    = 1'b0;
      w_mem_wdata = w_shift_in[DATA_WIDTH-1:0];
      if (SS_n) begin
         // Partial words are simply dropped; pointers stay as they are
         w_cnt_d = '0;
      end else begin
         case (r_state)
            StIdle: w_cnt_d = '0;
            StGetOp: begin
               if (r_cnt == '0) begin
                  w_op_hi_d = MOSI;
                  w_cnt_d   = CntW'(1);
               end else begin
                  w_cnt_d = '0;
               end
            end
            StAddr: begin
               w_shift_d = w_shift_in;
               if (r_cnt == AddrLast) begin
                  w_cnt_d = '0;
                  if (r_op_hi) begin
                     w_rd_ptr_d = w_shift_in[ADDR_WIDTH-1:0];
                  end else begin
                     w_wr_ptr_d = w_shift_in[ADDR_WIDTH-1:0];
                  end
               end else begin
                  w_cnt_d = r_cnt + CntW'(1);
               end
            end
            StWdata: begin
               w_shift_d = w_shift_in;
               if (r_cnt == DataLast) begin
                  w_cnt_d    = '0;
                  w_mem_we   = 1'b1;
                  w_wr_ptr_d = w_wr_inc;
               end else begin
                  w_cnt_d = r_cnt + CntW'(1);
               end
            end
            StRdata: begin
               if (r_cnt == '0) begin
                  // Fetch the next word and drive its MSB in the same cycle so words abut
                  w_miso_d   = w_rd_word[DATA_WIDTH-1];
                  w_shift_d  = MaxW'(w_rd_word) << 1;
                  w_rd_ptr_d = w_rd_inc;
               end else begin
                  w_miso_d  = r_shift[DATA_WIDTH-1];
                  w_shift_d = r_shift << 1;
               end
               w_cnt_d = (r_cnt == DataLast) ? '0 : r_cnt + CntW'(1);
            end
            default: ;
         endcase
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_shift  <= '0;
         r_op_hi  <= 1'b0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_miso   <= 1'b0;
      end else begin
         r_cnt    <= w_cnt_d;
         r_shift  <= w_shift_d;
         r_op_hi  <= w_op_hi_d;
         r_wr_ptr <= w_wr_ptr_d;
         r_rd_ptr <= w_rd_ptr_d;
         r_miso   <= w_miso_d;
      end
   end

   // Memory write port; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[r_wr_ptr[IdxW-1:0]] <= w_mem_wdata;
      end
   end

endmodule
